lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store controller for the MIPS MEM stage: the initiator side of the data-memory interface. It takes load/store commands from the EX/MEM pipeline register and drives a word-addressed data memory over a req/ack handshake. It performs byte-lane extraction with sign or zero extension for loads, and read-modify-write for sub-word stores. It stalls the pipeline until each access completes.

## Interface
Parameters:
- ADDR_W, 4, word-address width of the data memory (16 words).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- op_valid  in  1  MEM-stage instruction is a memory op
- op_load  in  1  load; if set together with op_store, the op is treated as a load
- op_store  in  1  store
- op_size  in  2  size: 00 byte, 01 half, 10 word; 11 is illegal and flags misalign
- op_signed  in  1  sign-extend sub-word loads
- addr  in  32  byte address (ALU result)
- wdata  in  32  store data, right-justified
- stall  out  1  hold pipeline
- load_valid  out  1  one-cycle pulse with load_data
- load_data  out  32  extended load result
- misalign  out  1  one-cycle alignment/size fault
- mem_req  out  1  memory request
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  word address = addr[ADDR_W+1:2]
- mem_wdata  out  32  write word
- mem_rdata  in  32  read word, valid in the ack cycle
- mem_ack  in  1  access complete

## Operation
- FSM states: IDLE, RD, RMW_RD, WR, DONE.
- IDLE:
  - Word or sub-word load goes to RD.
  - Word store goes to WR.
  - Sub-word store goes to RMW_RD.
  - Misaligned op (half with addr[0]=1, word with addr[1:0]≠0, size 11): misalign pulses for that cycle, no memory access, no stall, stay IDLE.
- Op latch on accept: addr[1:0], size, signed, wdata, word address.
- RD: mem_req=1, mem_we=0. On ack, capture the extracted and extended lane, then go to DONE.
- RMW_RD: read as in RD. On ack, merge the new byte/half into the read word, then go to WR.
- WR: mem_req=1, mem_we=1, mem_wdata = full word or merged word. On ack, go to DONE.
- DONE: stall=0. load_valid=1 for loads. Return to IDLE; op_valid is ignored in DONE.
- Lane extraction is little-endian:
  - byte lane = addr[1:0]
  - half lane = addr[1]
- Store merge replaces only the addressed lane.
- Extension: op_signed=1 replicates the lane MSB; op_signed=0 zero-fills.
- stall = (state∈{RD,RMW_RD,WR}) | (state==IDLE & op_valid & (op_load|op_store) & ~fault).

## Timing
- Reset values:
  - state IDLE
  - mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0
  - load_data 0, load_valid 0, misalign 0, stall 0
- mem_req, mem_we, mem_addr and mem_wdata are registered. They are held stable from request until the cycle mem_ack is sampled high.
- Memory may ack in the request cycle or any later cycle.
- With same-cycle ack:
  - load and word store: 2 stall cycles
  - sub-word store: 3 stall cycles
- Each extra wait cycle adds one stall cycle.
- mem_ack outside RD/RMW_RD/WR is ignored.
- Reset mid-access:
  - mem_req drops asynchronously and state goes to IDLE.
  - A late ack after reset release is ignored.
  - No load_valid is produced.
- load_data holds its last value until the next completed load.

## Configuration
- LSU_SUBWORD_EN defined: full byte/half support as above.
- LSU_SUBWORD_EN undefined:
  - Only op_size=10 is legal; 00 and 01 raise misalign like 11.
  - RMW_RD state and the lane mux/merge logic are removed.
  - op_signed is ignored.

## Structure
- Shared package mips_mem_pkg:
  - op_size encodings (SZ_BYTE, SZ_HALF, SZ_WORD)
  - FSM state enum
  - DMEM_ADDR_W default
- Sub-module lsu_align (combinational):
  - load lane extract and extend: rdata, offset, size, signed → 32-bit result
  - store merge: old word, wdata, offset, size → new word
- lsu_ctrl contains the FSM, latches and handshake.

## Test plan
- Word store then load: store 0xDEADBEEF at addr 0x8 → mem_addr=2, mem_we=1, 2 stall cycles. Load 0x8 → load_data=0xDEADBEEF, load_valid one cycle.
- Signed byte load: word 0x80FF7F01 at addr 0x4.
  - lb addr 0x7 → 0xFFFFFF80
  - lbu addr 0x7 → 0x00000080
  - lb addr 0x4 → 0x00000001
- Sub-word store RMW: word 0x11223344 at addr 0xC; sh 0xABCD to 0xE → memory read, then write 0xABCD3344, 3 stall cycles.
- Misalign: lw 0x6 and lh 0x3 → misalign pulse, mem_req never asserted, stall=0.
- Wait states: memory acks 3 cycles after req → mem_req/addr stable throughout, stall=4 cycles, correct data.
- Reset in RD with ack pending → mem_req=0 immediately. A subsequent ack produces no load_valid. The next load completes normally.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg
// Shared definitions for the MIPS MEM-stage data-memory path:
//   - DMEM_ADDR_W : default word-address width of the data memory
//   - SZ_*        : op_size encodings (byte, half, word; 2'b11 is illegal)
//   - lsu_state_e : load/store controller FSM states
package mips_mem_pkg;

    localparam int DMEM_ADDR_W = 4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RMW_RD,
        WR,
        DONE
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// lsu_align
// Combinational little-endian byte-lane logic for the load/store controller.
// Ports:
//   rdata       in  32  word read from memory
//   offset      in  2   byte offset within the word (addr[1:0])
//   size        in  2   SZ_BYTE / SZ_HALF / SZ_WORD
//   sign_ext    in  1   replicate lane MSB when set, zero-fill otherwise
//   load_result out 32  extracted and extended load value
//   old_word    in  32  current memory word for read-modify-write
//   wdata       in  32  right-justified store data
//   merged      out 32  old_word with only the addressed lane replaced
module lsu_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] load_result,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] merged
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[{offset, 3'b000} +: 8];
        half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: load_result = {{24{sign_ext & byte_lane[7]}}, byte_lane};
            SZ_HALF: load_result = {{16{sign_ext & half_lane[15]}}, half_lane};
            default: load_result = rdata;
        endcase
    end

    always_comb begin
        merged = old_word;
        case (size)
            SZ_BYTE: merged[{offset, 3'b000} +: 8] = wdata[7:0];
            SZ_HALF: begin
                if (offset[1]) merged[31:16] = wdata[15:0];
                else           merged[15:0]  = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl
// MEM-stage load/store controller: initiator side of a word-addressed data
// memory with a req/ack handshake. Stalls the pipeline until each access
// completes. Build option LSU_SUBWORD_EN enables byte/half loads (lane
// extract + sign/zero extension) and sub-word stores (read-modify-write);
// without it only word accesses are legal and anything else flags misalign.
// Ports:
//   clk, rst                async active-high reset
//   op_valid/op_load/op_store/op_size/op_signed/addr/wdata   command in
//   stall                   hold pipeline
//   load_valid, load_data   one-cycle load result pulse, held data
//   misalign                one-cycle alignment/size fault
//   mem_req/mem_we/mem_addr/mem_wdata   registered memory request
//   mem_rdata/mem_ack       memory response
module lsu_ctrl
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic              op_load,
    input  logic              op_store,
    input  logic [1:0]        op_size,
    input  logic              op_signed,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic              load_valid,
    output logic [31:0]       load_data,
    output logic              misalign,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    lsu_state_e  state;
    logic        mem_op;
    logic        fault;
    logic        accept;
    logic [31:0] load_ext;

    function automatic logic size_fault(input logic [1:0] sz, input logic [1:0] a);
`ifdef LSU_SUBWORD_EN
        case (sz)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return a[0];
            SZ_WORD: return (a != 2'b00);
            default: return 1'b1;
        endcase
`else
        return (sz != SZ_WORD) || (a != 2'b00);
`endif
    endfunction

    assign mem_op   = op_valid & (op_load | op_store);
    assign fault    = size_fault(op_size, addr[1:0]);
    assign accept   = (state == IDLE) & mem_op & ~fault;
    assign misalign = ~rst & (state == IDLE) & mem_op & fault;
    assign stall    = ~rst & ((state == RD) | (state == RMW_RD) | (state == WR) | accept);

`ifdef LSU_SUBWORD_EN
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        sgn_q;
    logic [31:0] wdata_q;
    logic [31:0] merged;
    logic        unused_bits;

    assign unused_bits = ^{addr[31:ADDR_W+2]};

    // Operand latch: the pipeline may change its inputs once the access is
    // under way, so lane/size/data are captured at accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            off_q   <= addr[1:0];
            size_q  <= op_size;
            sgn_q   <= op_signed;
            wdata_q <= wdata;
        end
    end

    lsu_align u_align (
        .rdata       (mem_rdata),
        .offset      (off_q),
        .size        (size_q),
        .sign_ext    (sgn_q),
        .load_result (load_ext),
        .old_word    (mem_rdata),
        .wdata       (wdata_q),
        .merged      (merged)
    );
`else
    logic unused_bits;

    assign unused_bits = ^{op_signed, addr[31:ADDR_W+2]};
    assign load_ext    = mem_rdata;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            load_data  <= '0;
            load_valid <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        mem_req  <= 1'b1;
                        mem_addr <= addr[ADDR_W+1:2];
                        // A load wins when both load and store are set.
                        if (op_load) begin
                            mem_we <= 1'b0;
                            state  <= RD;
`ifdef LSU_SUBWORD_EN
                        end else if (op_size != SZ_WORD) begin
                            mem_we <= 1'b0;
                            state  <= RMW_RD;
`endif
                        end else begin
                            mem_we    <= 1'b1;
                            mem_wdata <= wdata;
                            state     <= WR;
                        end
                    end
                end
                RD: begin
                    if (mem_ack) begin
                        mem_req    <= 1'b0;
                        load_data  <= load_ext;
                        load_valid <= 1'b1;
                        state      <= DONE;
                    end
                end
`ifdef LSU_SUBWORD_EN
                RMW_RD: begin
                    // mem_req stays high straight into the write phase.
                    if (mem_ack) begin
                        mem_we    <= 1'b1;
                        mem_wdata <= merged;
                        state     <= WR;
                    end
                end
`endif
                WR: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl
// Directed bench for lsu_ctrl with a small 16-word memory responder whose
// ack latency is adjustable. Sub-word scenarios expect real byte/half
// behaviour when LSU_SUBWORD_EN is defined and a misalign fault otherwise.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid, op_load, op_store, op_signed;
    logic [1:0]  op_size;
    logic [31:0] addr, wdata;
    logic        stall, load_valid, misalign, mem_req, mem_we;
    logic [31:0] load_data, mem_wdata, mem_rdata;
    logic [3:0]  mem_addr;
    logic        mem_ack;

    logic [31:0] mem [16];
    int          delay;
    int          cnt;
    logic        auto_ack;
    logic        man_ack;
    logic        resp_ack;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_load(op_load),
        .op_store(op_store), .op_size(op_size), .op_signed(op_signed),
        .addr(addr), .wdata(wdata), .stall(stall), .load_valid(load_valid),
        .load_data(load_data), .misalign(misalign), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    assign mem_ack = auto_ack ? resp_ack : man_ack;

    // Memory responder: acks after `delay` wait cycles of a held request.
    always @(negedge clk) begin
        if (mem_req) begin
            if (cnt >= delay) begin
                resp_ack  = 1'b1;
                mem_rdata = mem[mem_addr];
                if (mem_we && auto_ack) mem[mem_addr] = mem_wdata;
                cnt = 0;
            end else begin
                resp_ack = 1'b0;
                cnt++;
            end
        end else begin
            resp_ack = 1'b0;
            cnt = 0;
        end
    end

    task automatic do_op(input logic ld, input logic st, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a, input logic [31:0] wd,
                         output int stalls, output int lv, output logic [31:0] data,
                         output int mis, output int reqs, output logic we_last,
                         output logic [3:0] addr_last, output logic addr_stable);
        @(posedge clk); #1;
        op_valid = 1'b1; op_load = ld; op_store = st; op_size = sz;
        op_signed = sg; addr = a; wdata = wd;
        stalls = 0; lv = 0; data = 'x; mis = 0; reqs = 0;
        we_last = 1'b0; addr_last = 'x; addr_stable = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (stall) stalls++;
            if (misalign) mis++;
            if (load_valid) begin lv++; data = load_data; end
            if (mem_req) begin
                if (reqs > 0 && mem_addr !== addr_last) addr_stable = 1'b0;
                reqs++;
                we_last = mem_we;
                addr_last = mem_addr;
            end
            if (!stall) break;
        end
        @(posedge clk); #1;
        op_valid = 1'b0; op_load = 1'b0; op_store = 1'b0;
        @(negedge clk);
        if (load_valid) lv++;
        if (misalign) mis++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b expected 0", stall); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req: got %b expected 0", mem_req); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we: got %b expected 0", mem_we); end
        n_checks++; if (mem_addr !== 4'h0) begin n_fail++; $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); end
        n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_mem_wdata: got %h expected 0", mem_wdata); end
        n_checks++; if (load_data !== 32'h0) begin n_fail++; $display("FAIL rst_load_data: got %h expected 0", load_data); end
        n_checks++; if (load_valid !== 1'b0) begin n_fail++; $display("FAIL rst_load_valid: got %b expected 0", load_valid); end
        n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL rst_misalign: got %b expected 0", misalign); end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_word_store_load;
        int st, lv, mis, reqs; logic [31:0] d; logic we; logic [3:0] ma; logic stab;
        do_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF, st, lv, d, mis, reqs, we, ma, stab);
        n_checks++; if (st !== 2) begin n_fail++; $display("FAIL sw_stall: got %0d expected 2", st); end
        n_checks++; if (we !== 1'b1) begin n_fail++; $display("FAIL sw_we: got %b expected 1", we); end
        n_checks++; if (ma !== 4'd2) begin n_fail++; $display("FAIL sw_addr: got %0d expected 2", ma); end
        n_checks++; if (mem[2] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_mem: got %h expected deadbeef", mem[2]); end
        n_checks++; if (lv !== 0) begin n_fail++; $display("FAIL sw_load_valid: got %0d expected 0", lv); end
        do_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, st, lv, d, mis, reqs, we, ma, stab);
        n_checks++; if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_data: got %h expected deadbeef", d); end
        n_checks++; if (lv !== 1) begin n_fail++; $display("FAIL lw_valid_pulses: got %0d expected 1", lv); end
        n_checks++; if (st !== 2) begin n_fail++; $display("FAIL lw_stall: got %0d expected 2", st); end
        n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL lw_we: got %b expected 0", we); end
        n_checks++; if (load_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_hold: got %h expected deadbeef", load_data); end
    endtask

    task automatic test_byte_load;
        int st, lv, mis, reqs; logic [31:0] d; logic we; logic [3:0] ma; logic stab;
        logic [1:0]  sz [4]  = '{2'b00, 2'b00, 2'b00, 2'b01};
        logic        sg [4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] ad [4]  = '{32'h7, 32'h7, 32'h4, 32'h6};
        logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'h00000001, 32'hFFFF80FF};
        mem[1] = 32'h80FF7F01;
        for (int i = 0; i < 4; i++) begin
            do_op(1'b1, 1'b0, sz[i], sg[i], ad[i], 32'h0, st, lv, d, mis, reqs, we, ma, stab);
`ifdef LSU_SUBWORD_EN
            n_checks++; if (d !== exp[i]) begin n_fail++; $display("FAIL subload_%0d_data: got %h expected %h", i, d, exp[i]); end
            n_checks++; if (st !== 2) begin n_fail++; $display("FAIL subload_%0d_stall: got %0d expected 2", i, st); end
`else
            n_checks++; if (mis !== 1) begin n_fail++; $display("FAIL subload_%0d_misalign: got %0d expected 1", i, mis); end
            n_checks++; if (reqs !== 0) begin n_fail++; $display("FAIL subload_%0d_req: got %0d expected 0 (exp data %h unused)", i, reqs, exp[i]); end
`endif
        end
    endtask

    task automatic test_rmw;
        int st, lv, mis, reqs; logic [31:0] d; logic we; logic [3:0] ma; logic stab;
        mem[3] = 32'h11223344;
        do_op(1'b0, 1'b1, 2'b01, 1'b0, 32'hE, 32'h0000ABCD, st, lv, d, mis, reqs, we, ma, stab);
`ifdef LSU_SUBWORD_EN
        n_checks++; if (mem[3] !== 32'hABCD3344) begin n_fail++; $display("FAIL sh_mem: got %h expected abcd3344", mem[3]); end
        n_checks++; if (st !== 3) begin n_fail++; $display("FAIL sh_stall: got %0d expected 3", st); end
        n_checks++; if (reqs !== 2) begin n_fail++; $display("FAIL sh_req_cycles: got %0d expected 2", reqs); end
        do_op(1'b0, 1'b1, 2'b00, 1'b0, 32'hD, 32'hFFFFFF55, st, lv, d, mis, reqs, we, ma, stab);
        n_checks++; if (mem[3] !== 32'hABCD5544) begin n_fail++; $display("FAIL sb_mem: got %h expected abcd5544", mem[3]); end
        n_checks++; if (st !== 3) begin n_fail++; $display("FAIL sb_stall: got %0d expected 3", st); end
`else
        n_checks++; if (mis !== 1) begin n_fail++; $display("FAIL sh_misalign: got %0d expected 1", mis); end
        n_checks++; if (mem[3] !== 32'h11223344) begin n_fail++; $display("FAIL sh_mem_untouched: got %h expected 11223344", mem[3]); end
        n_checks++; if (st !== 0) begin n_fail++; $display("FAIL sh_stall: got %0d expected 0", st); end
`endif
    endtask

    task automatic test_misalign;
        int st, lv, mis, reqs; logic [31:0] d; logic we; logic [3:0] ma; logic stab;
        logic [1:0]  sz [3] = '{2'b10, 2'b01, 2'b11};
        logic [31:0] ad [3] = '{32'h6, 32'h3, 32'h0};
        for (int i = 0; i < 3; i++) begin
            do_op(1'b1, 1'b0, sz[i], 1'b0, ad[i], 32'h0, st, lv, d, mis, reqs, we, ma, stab);
            n_checks++; if (mis !== 1) begin n_fail++; $display("FAIL mis_%0d_pulse: got %0d expected 1", i, mis); end
            n_checks++; if (reqs !== 0) begin n_fail++; $display("FAIL mis_%0d_req: got %0d expected 0", i, reqs); end
            n_checks++; if (st !== 0) begin n_fail++; $display("FAIL mis_%0d_stall: got %0d expected 0", i, st); end
        end
    endtask

    task automatic test_wait_states;
        int st, lv, mis, reqs; logic [31:0] d; logic we; logic [3:0] ma; logic stab;
        // Ack arrives in the third request cycle (two wait cycles).
        delay = 2;
        do_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, st, lv, d, mis, reqs, we, ma, stab);
        n_checks++; if (st !== 4) begin n_fail++; $display("FAIL wait_stall: got %0d expected 4", st); end
        n_checks++; if (reqs !== 3) begin n_fail++; $display("FAIL wait_req_cycles: got %0d expected 3", reqs); end
        n_checks++; if (stab !== 1'b1) begin n_fail++; $display("FAIL wait_addr_stable: got %b expected 1", stab); end
        n_checks++; if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wait_data: got %h expected deadbeef", d); end
        do_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h14, 32'h0BADF00D, st, lv, d, mis, reqs, we, ma, stab);
        n_checks++; if (st !== 4) begin n_fail++; $display("FAIL wait_sw_stall: got %0d expected 4", st); end
        n_checks++; if (mem[5] !== 32'h0BADF00D) begin n_fail++; $display("FAIL wait_sw_mem: got %h expected 0badf00d", mem[5]); end
        delay = 0;
    endtask

    task automatic test_reset_mid_access;
        int st, lv, mis, reqs; logic [31:0] d; logic we; logic [3:0] ma; logic stab;
        logic seen_lv;
        auto_ack = 1'b0; man_ack = 1'b0; seen_lv = 1'b0;
        @(posedge clk); #1;
        op_valid = 1'b1; op_load = 1'b1; op_store = 1'b0; op_size = 2'b10; addr = 32'h8;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rmid_req_before: got %b expected 1", mem_req); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rmid_req_async: got %b expected 0", mem_req); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rmid_stall: got %b expected 0", stall); end
        op_valid = 1'b0; op_load = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1 man_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (load_valid) seen_lv = 1'b1;
            @(posedge clk); #1 man_ack = 1'b0;
        end
        n_checks++; if (seen_lv !== 1'b0) begin n_fail++; $display("FAIL rmid_late_ack_lv: got %b expected 0", seen_lv); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rmid_req_after: got %b expected 0", mem_req); end
        auto_ack = 1'b1;
        do_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, st, lv, d, mis, reqs, we, ma, stab);
        n_checks++; if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rmid_next_data: got %h expected deadbeef", d); end
        n_checks++; if (lv !== 1) begin n_fail++; $display("FAIL rmid_next_valid: got %0d expected 1", lv); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        delay = 0; cnt = 0; auto_ack = 1'b1; man_ack = 1'b0; resp_ack = 1'b0;
        mem_rdata = 32'h0;
        op_valid = 1'b0; op_load = 1'b0; op_store = 1'b0; op_size = 2'b10;
        op_signed = 1'b0; addr = 32'h0; wdata = 32'h0;
        test_reset;
        test_word_store_load;
        test_byte_load;
        test_rmw;
        test_misalign;
        test_wait_states;
        test_reset_mid_access;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
